// File: rtl/mem_arbiter_pkg.sv
// Shared types for the three-requester BRAM arbiter: FSM states, requester ids and helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_LD = 2'd0,
        REQ_EX = 2'd1,
        REQ_IF = 2'd2
    } req_id_t;

    // Wide enough to count the remaining WAIT cycles for the largest read latency (7).
    localparam int unsigned WaitCntW = 3;

    function automatic logic req_is_write(input req_id_t id, input logic ex_we);
        logic wr;
        wr = 1'b0;
        unique case (id)
            REQ_LD:  wr = 1'b1;
            REQ_EX:  wr = ex_we;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection: loader always first, execute/fetch ordered by prefer_ex_i.
module mem_arbiter_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic    ld_req_i,
    input  logic    ex_req_i,
    input  logic    if_req_i,
    input  logic    prefer_ex_i,
    output logic    valid_o,
    output req_id_t id_o
);

    always_comb begin
        valid_o = ld_req_i | ex_req_i | if_req_i;
        id_o    = REQ_LD;
        if (ld_req_i) begin
            id_o = REQ_LD;
        end else if (ex_req_i && if_req_i) begin
            id_o = prefer_ex_i ? REQ_EX : REQ_IF;
        end else if (ex_req_i) begin
            id_o = REQ_EX;
        end else if (if_req_i) begin
            id_o = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter for loader, execute and fetch; one transaction outstanding.
// Define MEM_ARBITER_RR_EN to alternate execute/fetch when both pend (loader stays on top).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,

    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_gnt,
    output logic              ex_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // WAIT is entered after ACCESS, so it lasts RD_LAT-1 cycles; the counter starts at RD_LAT-2.
    localparam logic [WaitCntW-1:0] WaitInit =
        (RD_LAT >= 2) ? WaitCntW'(RD_LAT - 2) : '0;

    arb_state_t            state_q;
    req_id_t               win_q;
    logic                  rd_q;
    logic [WaitCntW-1:0]   cnt_q;

    logic                  ld_gnt_q;
    logic                  ex_gnt_q;
    logic                  if_gnt_q;
    logic                  ex_rvalid_q;
    logic                  if_rvalid_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  pick_valid;
    req_id_t               pick_id;
    logic                  prefer_ex;
    logic                  rvalid_any;

`ifdef MEM_ARBITER_RR_EN
    logic                  prefer_ex_q;
    assign prefer_ex = prefer_ex_q;
`else
    assign prefer_ex = 1'b1;
`endif

    mem_arbiter_arb_pick u_arb_pick (
        .ld_req_i    (ld_req),
        .ex_req_i    (ex_req),
        .if_req_i    (if_req),
        .prefer_ex_i (prefer_ex),
        .valid_o     (pick_valid),
        .id_o        (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= REQ_LD;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            ld_gnt_q    <= 1'b0;
            ex_gnt_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            ex_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_ARBITER_RR_EN
            prefer_ex_q <= 1'b1;
`endif
        end else begin
            // Grant, enable and rvalid are single-cycle pulses.
            ld_gnt_q    <= 1'b0;
            ex_gnt_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            ex_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;

            if (rvalid_any) begin
                rdata_q <= mem_rdata;
            end

            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        win_q    <= pick_id;
                        rd_q     <= ~req_is_write(pick_id, ex_we);
                        mem_en_q <= 1'b1;
                        mem_we_q <= req_is_write(pick_id, ex_we);
                        state_q  <= ACCESS;
                        unique case (pick_id)
                            REQ_LD: begin
                                ld_gnt_q    <= 1'b1;
                                mem_addr_q  <= ld_addr;
                                mem_wdata_q <= ld_wdata;
                            end
                            REQ_EX: begin
                                ex_gnt_q    <= 1'b1;
                                mem_addr_q  <= ex_addr;
                                mem_wdata_q <= ex_wdata;
                            end
                            REQ_IF: begin
                                if_gnt_q    <= 1'b1;
                                mem_addr_q  <= if_addr;
                            end
                            default: ;
                        endcase
`ifdef MEM_ARBITER_RR_EN
                        if (pick_id == REQ_EX) begin
                            prefer_ex_q <= 1'b0;
                        end else if (pick_id == REQ_IF) begin
                            prefer_ex_q <= 1'b1;
                        end
`endif
                    end
                end

                ACCESS: begin
                    if (!rd_q) begin
                        state_q <= IDLE;
                    end else if (RD_LAT == 1) begin
                        ex_rvalid_q <= (win_q == REQ_EX);
                        if_rvalid_q <= (win_q == REQ_IF);
                        state_q     <= IDLE;
                    end else begin
                        cnt_q   <= WaitInit;
                        state_q <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt_q == '0) begin
                        ex_rvalid_q <= (win_q == REQ_EX);
                        if_rvalid_q <= (win_q == REQ_IF);
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rvalid_any = ex_rvalid_q | if_rvalid_q;

    // Read data is live from the BRAM during the rvalid cycle and held afterwards.
    assign rdata     = rvalid_any ? mem_rdata : rdata_q;
    assign ld_gnt    = ld_gnt_q;
    assign ex_gnt    = ex_gnt_q;
    assign if_gnt    = if_gnt_q;
    assign ex_rvalid = ex_rvalid_q;
    assign if_rvalid = if_rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RD_LAT=2 instance with a small BRAM model plus an RD_LAT=1 instance.
module tb_mem_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic          ex_req;
    logic          ex_we;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic          ex_gnt;
    logic          ex_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          if_req1;
    logic [AW-1:0] if_addr1;
    logic          ld_gnt1;
    logic          if_gnt1;
    logic          if_rvalid1;
    logic          ex_gnt1;
    logic          ex_rvalid1;
    logic [DW-1:0] rdata1;
    logic          mem_en1;
    logic          mem_we1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wdata1;
    logic [DW-1:0] mem_rdata1;

    int total;
    int bad;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .ex_req    (ex_req),
        .ex_we     (ex_we),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_gnt    (ex_gnt),
        .ex_rvalid (ex_rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (1'b0),
        .ld_addr   ({AW{1'b0}}),
        .ld_wdata  ({DW{1'b0}}),
        .ld_gnt    (ld_gnt1),
        .if_req    (if_req1),
        .if_addr   (if_addr1),
        .if_gnt    (if_gnt1),
        .if_rvalid (if_rvalid1),
        .ex_req    (1'b0),
        .ex_we     (1'b0),
        .ex_addr   ({AW{1'b0}}),
        .ex_wdata  ({DW{1'b0}}),
        .ex_gnt    (ex_gnt1),
        .ex_rvalid (ex_rvalid1),
        .rdata     (rdata1),
        .mem_en    (mem_en1),
        .mem_we    (mem_we1),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_rdata (mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage read pipeline: data appears two cycles after the enable cycle.
    logic [DW-1:0] bram [0:255];
    logic [DW-1:0] rd_pipe0;
    logic [DW-1:0] rd_pipe1;

    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr[7:0]] <= mem_wdata;
        rd_pipe0 <= (mem_en && !mem_we) ? bram[mem_addr[7:0]] : 32'h0;
        rd_pipe1 <= rd_pipe0;
        mem_rdata1 <= (mem_en1 && !mem_we1) ? (32'hCAFE0000 | 32'(mem_addr1)) : 32'h0;
    end
    assign mem_rdata = rd_pipe1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic exp_ex [4];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) bram[i] = '0;
`ifdef MEM_ARBITER_RR_EN
        exp_ex[0] = 1'b1; exp_ex[1] = 1'b0; exp_ex[2] = 1'b1; exp_ex[3] = 1'b0;
`else
        exp_ex[0] = 1'b1; exp_ex[1] = 1'b1; exp_ex[2] = 1'b1; exp_ex[3] = 1'b1;
`endif
        rst = 1'b1;
        ld_req = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0;
        ex_req = 0; ex_we = 0; ex_addr = '0; ex_wdata = '0;
        if_req1 = 0; if_addr1 = '0;

        // Reset state
        tick(); tick();
        check("rst_gnts", {ld_gnt, ex_gnt, if_gnt}, 3'b000);
        check("rst_rvalid", {ex_rvalid, if_rvalid}, 2'b00);
        check("rst_mem_en_we", {mem_en, mem_we}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 19'h0);
        rst = 1'b0;

        // Loader write at T0
        ld_req = 1; ld_addr = 19'h10; ld_wdata = 32'hDEADBEEF;
        tick();
        check("ld_gnt_t1", ld_gnt, 1'b1);
        check("ld_other_gnt_t1", {ex_gnt, if_gnt}, 2'b00);
        check("ld_mem_en_we_t1", {mem_en, mem_we}, 2'b11);
        check("ld_mem_addr_t1", mem_addr, 19'h10);
        check("ld_mem_wdata_t1", mem_wdata, 32'hDEADBEEF);
        ld_req = 0;
        tick();
        check("ld_t2_quiet", {ld_gnt, mem_en, mem_we, ex_rvalid, if_rvalid}, 5'b0);

        // Fetch read issued right at T2 proves the loader write returned to IDLE
        if_req = 1; if_addr = 19'h10;
        tick();
        check("if_gnt_t1", {ld_gnt, ex_gnt, if_gnt}, 3'b001);
        check("if_mem_en_we_t1", {mem_en, mem_we}, 2'b10);
        check("if_mem_addr_t1", mem_addr, 19'h10);
        tick();
        check("if_t2_hold_ignored", {if_gnt, mem_en, if_rvalid}, 3'b000);
        if_req = 0;
        tick();
        check("if_rvalid_t3", {if_rvalid, ex_rvalid}, 2'b10);
        check("if_rdata_t3", rdata, 32'hDEADBEEF);
        tick();
        check("if_t4_quiet", {if_rvalid, if_gnt, mem_en}, 3'b000);
        check("if_rdata_held", rdata, 32'hDEADBEEF);

        // All three at once: ld, then ex (store), then if
        ld_req = 1; ld_addr = 19'h30; ld_wdata = 32'hA5A5A5A5;
        ex_req = 1; ex_we = 1; ex_addr = 19'h20; ex_wdata = 32'h11112222;
        if_req = 1; if_addr = 19'h20;
        tick();
        check("pri_t1_gnts", {ld_gnt, ex_gnt, if_gnt}, 3'b100);
        check("pri_t1_addr", mem_addr, 19'h30);
        ld_req = 0;
        tick();
        check("pri_t2_gnts", {ld_gnt, ex_gnt, if_gnt, mem_en}, 4'b0000);
        tick();
        check("pri_t3_gnts", {ld_gnt, ex_gnt, if_gnt}, 3'b010);
        check("pri_t3_mem", {mem_en, mem_we}, 2'b11);
        check("pri_t3_addr", mem_addr, 19'h20);
        check("pri_t3_wdata", mem_wdata, 32'h11112222);
        ex_req = 0; ex_we = 0;
        tick();
        check("pri_t4_gnts", {ld_gnt, ex_gnt, if_gnt, mem_en}, 4'b0000);
        tick();
        check("pri_t5_gnts", {ld_gnt, ex_gnt, if_gnt}, 3'b001);
        check("pri_t5_mem", {mem_en, mem_we}, 2'b10);
        if_req = 0;
        tick();
        tick();
        check("pri_if_rvalid", if_rvalid, 1'b1);
        check("pri_if_rdata", rdata, 32'h11112222);

        // ex load and if fetch held continuously
        tick();
        ex_req = 1; ex_we = 0; ex_addr = 19'h30;
        if_req = 1; if_addr = 19'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_ex_gnt", ex_gnt, exp_ex[i]);
            check("rr_if_gnt", if_gnt, !exp_ex[i]);
            check("rr_mem_we", {mem_en, mem_we}, 2'b10);
            tick();
            check("rr_t2_quiet", {ex_gnt, if_gnt, mem_en}, 3'b000);
            tick();
            check("rr_ex_rvalid", ex_rvalid, exp_ex[i]);
            check("rr_if_rvalid", if_rvalid, !exp_ex[i]);
            check("rr_rdata", rdata, exp_ex[i] ? 32'hA5A5A5A5 : 32'h11112222);
        end
        ex_req = 0;
        if_req = 0;

        // Reset during WAIT of an ex load abandons it
        tick();
        ex_req = 1; ex_we = 0; ex_addr = 19'h30;
        tick();
        check("abort_ex_gnt", ex_gnt, 1'b1);
        ex_req = 0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_outputs", {ex_rvalid, if_rvalid, ld_gnt, ex_gnt, if_gnt, mem_en, mem_we},
              7'b0);
        check("abort_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("abort_no_rvalid", {ex_rvalid, ex_gnt, mem_en}, 3'b000);
        if_req = 1; if_addr = 19'h10;
        tick();
        check("post_rst_if_gnt", {ld_gnt, ex_gnt, if_gnt}, 3'b001);
        if_req = 0;
        tick();
        check("post_rst_t2", {if_rvalid, ex_rvalid}, 2'b00);
        tick();
        check("post_rst_if_rvalid", {if_rvalid, ex_rvalid}, 2'b10);
        check("post_rst_rdata", rdata, 32'hDEADBEEF);

        // RD_LAT=1 instance: WAIT skipped, rvalid at T2
        tick();
        if_req1 = 1; if_addr1 = 19'h5;
        tick();
        check("lat1_gnt", {ld_gnt1, ex_gnt1, if_gnt1}, 3'b001);
        check("lat1_mem", {mem_en1, mem_we1}, 2'b10);
        if_req1 = 0;
        tick();
        check("lat1_rvalid_t2", {if_rvalid1, ex_rvalid1, if_gnt1}, 3'b100);
        check("lat1_rdata_t2", rdata1, 32'hCAFE0005);
        tick();
        check("lat1_t3_quiet", {if_rvalid1, if_gnt1, mem_en1}, 3'b000);
        check("lat1_rdata_held", rdata1, 32'hCAFE0005);
        check("lat1_wdata_unused", mem_wdata1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
